// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential IEEE-754 multiplier.
package fp_mul_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;
  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fpclass_t;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_shift_add.sv
// Mantissa multiplier: one shift-add step per enabled cycle over MAN_W+1 multiplier bits.
module fp_mul_shift_add #(
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 en,
  input  logic [MAN_W:0]       ma,
  input  logic [MAN_W:0]       mb,
  output logic [2*MAN_W+1:0]   prod,
  output logic                 done
);
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW + 1);

  logic [PW-1:0] a_r;
  logic [MW-1:0] b_r;
  logic [PW-1:0] p_r;
  logic [CW-1:0] cnt;

  assign prod = p_r;
  assign done = en && (cnt == CW'(MAN_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
      cnt <= '0;
    end else if (start) begin
      a_r <= {{MW{1'b0}}, ma};
      b_r <= mb;
      p_r <= '0;
      cnt <= '0;
    end else if (en) begin
      if (b_r[0]) p_r <= p_r + a_r;
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier (RNE, flush-to-zero) with valid/ready on both sides.
// Define FP_MUL_FLAGS_EN to add the {NV,OF,UF,NX} flags port.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] EMAX   = XW'((1 << EXP_W) - 1);

  state_t state, state_d;
  logic [W-1:0] a_q, b_q, res_d;
  logic signed [XW-1:0] exp_q, exp_sum, exp_r;
  logic [PW-2:0] man_q;
  logic [PW-1:0] prod;
  logic [MAN_W:0] mant_r;
  logic mul_start, mul_done, load_res, sgn, g, st, up;
  fpclass_t ca, cb;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0] flg_d;
`endif

  function automatic fpclass_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    if (e == '0)           return ZERO;
    else if (e != '1)      return NORMAL;
    else if (m == '0)      return INF;
    else if (m[MAN_W-1])   return QNAN;
    else                   return SNAN;
  endfunction

  fp_mul_shift_add #(.MAN_W(MAN_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .en    (state == MUL),
    .ma    ({1'b1, a_q[MAN_W-1:0]}),
    .mb    ({1'b1, b_q[MAN_W-1:0]}),
    .prod  (prod),
    .done  (mul_done)
  );

  assign in_ready = (state == IDLE);

  always_comb begin
    state_d   = state;
    mul_start = 1'b0;
    load_res  = 1'b0;
    res_d     = '0;
`ifdef FP_MUL_FLAGS_EN
    flg_d     = '0;
`endif
    ca      = classify(a_q);
    cb      = classify(b_q);
    sgn     = a_q[W-1] ^ b_q[W-1];
    exp_sum = $signed({2'b00, a_q[W-2:MAN_W]}) + $signed({2'b00, b_q[W-2:MAN_W]}) - BIAS_X;
    // man_q holds the normalised product without its hidden bit
    g       = man_q[MAN_W];
    st      = |man_q[MAN_W-1:0];
    up      = g & (st | man_q[MAN_W+1]);
    mant_r  = {1'b0, man_q[PW-2:MAN_W+1]} + (MAN_W+1)'(up);
    exp_r   = exp_q + XW'(mant_r[MAN_W]);
    case (state)
      IDLE: if (in_valid) state_d = UNPACK;
      UNPACK: begin
        if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN ||
            (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
          res_d    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          load_res = 1'b1;
          state_d  = DONE;
`ifdef FP_MUL_FLAGS_EN
          flg_d[FLAG_NV] = (ca == SNAN) || (cb == SNAN) ||
                           (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF);
`endif
        end else if (ca == INF || cb == INF) begin
          res_d    = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          load_res = 1'b1;
          state_d  = DONE;
        end else if (ca == ZERO || cb == ZERO) begin
          res_d    = {sgn, {(W-1){1'b0}}};
          load_res = 1'b1;
          state_d  = DONE;
        end else begin
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      MUL:   if (mul_done) state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: begin
        load_res = 1'b1;
        state_d  = DONE;
        if (exp_r >= EMAX) begin
          res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
          flg_d[FLAG_OF] = 1'b1;
          flg_d[FLAG_NX] = 1'b1;
`endif
        end else if (exp_r <= $signed(XW'(0))) begin
          res_d = {sgn, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
          flg_d[FLAG_UF] = 1'b1;
          flg_d[FLAG_NX] = 1'b1;
`endif
        end else begin
          res_d = {sgn, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
`ifdef FP_MUL_FLAGS_EN
          flg_d[FLAG_NX] = g | st;
`endif
        end
      end
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      exp_q     <= '0;
      man_q     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
      flags     <= '0;
`endif
    end else begin
      state <= state_d;
      if (state == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == UNPACK) exp_q <= exp_sum;
      if (state == NORM) begin
        man_q <= prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        exp_q <= exp_q + XW'(prod[PW-1]);
      end
      if (load_res) begin
        result <= res_d;
`ifdef FP_MUL_FLAGS_EN
        flags  <= flg_d;
`endif
      end
      // valid rises one cycle after entering DONE and drops with the consuming handshake
      out_valid <= (state == DONE) && !(out_valid && out_ready);
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq (binary32); flag checks apply when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;
  int n_chk = 0;
  int n_fail = 0;

  fp_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

`ifndef FP_MUL_FLAGS_EN
  assign flags = 4'h0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [31:0] er, input logic [3:0] ef, input int el);
    int lat;
    int waits;
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_rdy"}, in_ready, 1);
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    if (el > 0) check({tag, "_lat"}, lat, el);
    check({tag, "_res"}, result, er);
`ifdef FP_MUL_FLAGS_EN
    check({tag, "_flg"}, flags, ef);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    @(negedge clk) rst = 1'b0;

    run_op("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 28);
    run_op("neg_product", 32'h3FC00000, 32'hC0200000, 32'hC0700000, 4'b0000, 28);
    run_op("inexact",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28);
    run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
    run_op("overflow",    32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 28);
    run_op("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 28);
    run_op("snan",        32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
    run_op("qnan_inf",    32'h7FC00000, 32'h7F800000, 32'h7FC00000, 4'b0000, 2);
    run_op("neg_inf",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);
    run_op("neg_zero",    32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 2);
    run_op("subnorm",     32'h00000001, 32'h40400000, 32'h00000000, 4'b0000, 2);
    run_op("norm_shift",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 28);
    run_op("round_up",    32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001, 28);
    run_op("tie_odd",     32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 28);
    run_op("tie_even",    32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 28);

    // consumer stall: output must hold and new operands must be refused
    out_ready = 1'b0;
    run_op("stall_op", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 28);
    held_res = result;
    held_flg = flags;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h40800000;
      b = 32'h40800000;
      in_valid = (i % 2) == 0;
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 32'h40C00000);
      check("stall_flags", flags, 4'b0000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("stall_release", out_valid, 0);
    run_op("after_stall", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

    // asynchronous reset in the middle of the multiply
    @(negedge clk);
    a = 32'h40000000;
    b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 check("mid_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    @(negedge clk) rst = 1'b0;
    run_op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
